// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch stage and control FSM.
// Instruction class codes are decoded from instr[15:14].
package cpu_pkg;

    localparam int ADDR_W_DEF = 16;

    typedef logic [15:0]           instr_t;
    typedef logic [ADDR_W_DEF-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } fetch_state_e;

    localparam logic [1:0] CLS_INV   = 2'b00;
    localparam logic [1:0] CLS_FMT1  = 2'b01;
    localparam logic [1:0] CLS_ARITH = 2'b10;
    localparam logic [1:0] CLS_FMT2  = 2'b11;

    function automatic logic [1:0] instr_cls(input instr_t i);
        return i[15:14];
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register with reset value and parallel load.
// Exposes pc+1 so the owner can select increment or redirect.
module pc_reg
    import cpu_pkg::*;
#(
    parameter int               ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_pc,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_inc
);

    // Increment wraps naturally at 2^ADDR_W.
    assign pc_inc = pc + ADDR_W'(1);

    // Reset beats load; load covers both redirect and increment.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_pc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, memory read sequencing, instruction
// register and valid/ready handoff to control, with redirect flush.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                MEM_LAT  = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    output instr_t            instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [1:0]        instr_class,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
);

    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    fetch_state_e      state;
    logic [2:0]        cnt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] load_pc;
    logic              capture;
    logic              load;

    // Capture happens in WAIT once the latency counter has run out.
    assign capture = (state == WAIT) && (cnt == 3'd0) && !redirect;
    assign load    = redirect | capture;
    assign load_pc = redirect ? redirect_pc : pc_inc;

    assign mem_addr    = pc;
    assign instr_class = instr_cls(instr);

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clock   (clock),
        .reset   (reset),
        .load    (load),
        .load_pc (load_pc),
        .pc      (pc),
        .pc_inc  (pc_inc)
    );

    // Fetch sequencer with registered read strobe and instruction register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 3'd0;
            mem_rd      <= 1'b0;
            instr       <= 16'h0000;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else if (redirect) begin
            state       <= IDLE;
            cnt         <= 3'd0;
            mem_rd      <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            mem_rd <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (run) begin
                        state  <= REQ;
                        mem_rd <= 1'b1;
                    end
                end
                REQ: begin
                    cnt   <= LAT_M1;
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt == 3'd0) begin
                        instr       <= mem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        state       <= HOLD;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                HOLD: begin
                    if (instr_valid && instr_ready) begin
                        instr_valid <= 1'b0;
                        if (run) begin
                            state  <= REQ;
                            mem_rd <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: two instances (latency 1 at
// PC 0, latency 3 at PC 0xFFFF) against a transaction-level model.
module tb_fetch_unit;

    logic        clock;
    logic        reset_s [2];
    logic        run_s   [2];
    logic        ready_s [2];
    logic        redir_s [2];
    logic [15:0] rpc_s   [2];
    logic        rd_o    [2];
    logic [15:0] addr_o  [2];
    logic [15:0] rdata_s [2];
    logic [15:0] instr_o [2];
    logic [15:0] ipc_o   [2];
    logic [1:0]  cls_o   [2];
    logic        vld_o   [2];

    int n_chk  = 0;
    int n_fail = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [15:0] word(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h8053;
            16'h0001: return 16'h2A11;
            16'h0010: return 16'h7FF0;
            16'h0040: return 16'h8AA1;
            16'hFFFF: return 16'hC123;
            default:  return a ^ 16'h5A5A;
        endcase
    endfunction

    task automatic chk(input string nm, input int inst,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h want %0h", nm, inst, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int          LAT = (g == 0) ? 1 : 3;
        localparam logic [15:0] RPC = (g == 0) ? 16'h0000 : 16'hFFFF;

        logic [15:0] pipe [LAT];
        logic [15:0] m_pc;
        logic [15:0] m_instr;
        logic [15:0] m_ipc;
        logic        m_valid;
        logic        m_rd;
        logic        fire;
        int          age;

        fetch_unit #(
            .ADDR_W   (16),
            .RESET_PC (RPC),
            .MEM_LAT  (LAT)
        ) dut (
            .clock       (clock),
            .reset       (reset_s[g]),
            .run         (run_s[g]),
            .mem_rd      (rd_o[g]),
            .mem_addr    (addr_o[g]),
            .mem_rdata   (rdata_s[g]),
            .instr       (instr_o[g]),
            .instr_pc    (ipc_o[g]),
            .instr_class (cls_o[g]),
            .instr_valid (vld_o[g]),
            .instr_ready (ready_s[g]),
            .redirect    (redir_s[g]),
            .redirect_pc (rpc_s[g])
        );

        // Memory: word appears exactly LAT cycles after the strobe.
        always @(posedge clock) begin
            for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
            pipe[0] <= (rd_o[g] === 1'b1) ? word(addr_o[g]) : 16'hEEEE;
        end
        assign rdata_s[g] = pipe[LAT-1];

        // Model: age counts cycles since the read strobe.
        always @(posedge clock) begin
            if (reset_s[g]) begin
                m_pc = RPC; m_valid = 0; m_instr = 0; m_ipc = 0;
                m_rd = 0; age = -1;
            end else if (redir_s[g]) begin
                m_pc = rpc_s[g]; m_valid = 0; m_rd = 0; age = -1;
            end else begin
                fire = 0;
                if (m_valid) begin
                    if (ready_s[g]) begin
                        m_valid = 0;
                        fire = run_s[g];
                    end
                end else if (age < 0) begin
                    fire = run_s[g];
                end else if (age == LAT) begin
                    m_instr = word(m_pc);
                    m_ipc = m_pc;
                    m_pc = m_pc + 16'd1;
                    m_valid = 1;
                    age = -1;
                end else begin
                    age++;
                end
                m_rd = fire;
                if (fire) age = 0;
            end
        end

        always @(negedge clock) begin
            chk("mem_rd", g, rd_o[g], m_rd);
            chk("mem_addr", g, addr_o[g], m_pc);
            chk("instr_valid", g, vld_o[g], m_valid);
            chk("instr", g, instr_o[g], m_instr);
            chk("instr_pc", g, ipc_o[g], m_ipc);
            chk("instr_class", g, cls_o[g], m_instr[15:14]);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            reset_s[i] = 1; run_s[i] = 0; ready_s[i] = 0;
            redir_s[i] = 0; rpc_s[i] = 16'h0000;
        end
        step(3);

        // Basic fetch at latency 1
        reset_s[0] = 0; run_s[0] = 1; ready_s[0] = 1;
        step(1);
        chk("t1_rd", 0, rd_o[0], 1);
        chk("t1_addr", 0, addr_o[0], 16'h0000);
        step(2);
        chk("t1_vld", 0, vld_o[0], 1);
        chk("t1_instr", 0, instr_o[0], 16'h8053);
        chk("t1_cls", 0, cls_o[0], 2'b10);
        chk("t1_ipc", 0, ipc_o[0], 16'h0000);
        step(1);
        chk("t1_rd2", 0, rd_o[0], 1);
        chk("t1_addr2", 0, addr_o[0], 16'h0001);

        // Backpressure in HOLD
        reset_s[0] = 1;
        step(1);
        reset_s[0] = 0; ready_s[0] = 0;
        step(3);
        for (int k = 0; k < 5; k++) begin
            chk("bp_vld", 0, vld_o[0], 1);
            chk("bp_instr", 0, instr_o[0], 16'h8053);
            chk("bp_ipc", 0, ipc_o[0], 16'h0000);
            chk("bp_rd", 0, rd_o[0], 0);
            chk("bp_pc", 0, addr_o[0], 16'h0001);
            if (k < 4) step(1);
        end
        ready_s[0] = 1;
        step(1);
        ready_s[0] = 0;
        chk("bp_xfer_vld", 0, vld_o[0], 0);
        chk("bp_rd_a1", 0, rd_o[0], 1);
        chk("bp_addr_a1", 0, addr_o[0], 16'h0001);
        step(2);
        chk("bp_vld2", 0, vld_o[0], 1);
        chk("bp_instr2", 0, instr_o[0], 16'h2A11);
        chk("bp_ipc2", 0, ipc_o[0], 16'h0001);
        chk("bp_cls2", 0, cls_o[0], 2'b00);

        // Redirect concurrent with transfer
        ready_s[0] = 1; redir_s[0] = 1; rpc_s[0] = 16'h0010;
        step(1);
        redir_s[0] = 0; ready_s[0] = 0;
        chk("rt_vld", 0, vld_o[0], 0);
        chk("rt_rd", 0, rd_o[0], 0);
        chk("rt_pc", 0, addr_o[0], 16'h0010);
        step(1);
        chk("rt_rd2", 0, rd_o[0], 1);
        chk("rt_addr2", 0, addr_o[0], 16'h0010);
        step(2);
        chk("rt_vld2", 0, vld_o[0], 1);
        chk("rt_ipc2", 0, ipc_o[0], 16'h0010);
        chk("rt_instr2", 0, instr_o[0], 16'h7FF0);

        // run falling in REQ
        reset_s[0] = 1;
        step(1);
        reset_s[0] = 0; run_s[0] = 1; ready_s[0] = 0;
        step(1);
        run_s[0] = 0;
        chk("rn_rd", 0, rd_o[0], 1);
        step(2);
        chk("rn_vld", 0, vld_o[0], 1);
        chk("rn_instr", 0, instr_o[0], 16'h8053);
        ready_s[0] = 1;
        step(1);
        ready_s[0] = 0;
        for (int k = 0; k < 10; k++) begin
            chk("rn_idle_rd", 0, rd_o[0], 0);
            chk("rn_idle_vld", 0, vld_o[0], 0);
            step(1);
        end
        run_s[0] = 1;
        step(1);
        chk("rn_resume_rd", 0, rd_o[0], 1);
        chk("rn_resume_addr", 0, addr_o[0], 16'h0001);
        step(3);
        reset_s[0] = 1;

        // Wrap, redirect in WAIT and reset in WAIT at latency 3
        reset_s[1] = 0; run_s[1] = 1; ready_s[1] = 1;
        step(1);
        chk("wr_rd", 1, rd_o[1], 1);
        chk("wr_addr", 1, addr_o[1], 16'hFFFF);
        step(4);
        chk("wr_vld", 1, vld_o[1], 1);
        chk("wr_ipc", 1, ipc_o[1], 16'hFFFF);
        chk("wr_instr", 1, instr_o[1], 16'hC123);
        chk("wr_cls", 1, cls_o[1], 2'b11);
        step(1);
        chk("wr_rd2", 1, rd_o[1], 1);
        chk("wr_addr2", 1, addr_o[1], 16'h0000);
        step(1);
        redir_s[1] = 1; rpc_s[1] = 16'h0040;
        chk("rw_rd", 1, rd_o[1], 0);
        step(1);
        redir_s[1] = 0; ready_s[1] = 0;
        chk("rw_vld", 1, vld_o[1], 0);
        chk("rw_pc", 1, addr_o[1], 16'h0040);
        step(1);
        chk("rw_rd2", 1, rd_o[1], 1);
        chk("rw_addr2", 1, addr_o[1], 16'h0040);
        step(1);
        chk("rw_nocap", 1, vld_o[1], 0);
        step(3);
        chk("rw_vld2", 1, vld_o[1], 1);
        chk("rw_ipc2", 1, ipc_o[1], 16'h0040);
        chk("rw_instr2", 1, instr_o[1], 16'h8AA1);
        ready_s[1] = 1;
        step(1);
        ready_s[1] = 0;
        chk("rs_rd", 1, rd_o[1], 1);
        chk("rs_addr", 1, addr_o[1], 16'h0041);
        step(1);
        reset_s[1] = 1;
        step(1);
        chk("rs_vld", 1, vld_o[1], 0);
        chk("rs_pc", 1, addr_o[1], 16'hFFFF);
        chk("rs_rd2", 1, rd_o[1], 0);
        step(3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the multicycle control FSM.
- Owns the program counter, drives a synchronous-read instruction memory, and latches the fetched word into an instruction register.
- Presents the instruction to control through a valid/ready handshake. Control pulses a redirect to load a new PC (jump/branch), which flushes any fetch in flight.

Parameters:
ADDR_W, 16, width of PC and instruction-memory address (word addressed)
RESET_PC, 0, PC value loaded on reset
MEM_LAT, 1, cycles from mem_rd assertion to valid mem_rdata (legal range 1..7)

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
run  in  1  fetch enable (step/run button level); new fetches start only while high
mem_rd  out  1  single-cycle read strobe to instruction memory
mem_addr  out  ADDR_W  read address, equal to PC while mem_rd high
mem_rdata  in  16  instruction word, sampled exactly MEM_LAT cycles after mem_rd
instr  out  16  instruction register contents
instr_pc  out  ADDR_W  address instr was fetched from
instr_class  out  2  instr[15:14] (00 invalid, 01 format I, 10 arith/logic, 11 format II)
instr_valid  out  1  instr holds an unconsumed instruction
instr_ready  in  1  control accepts instr this cycle
redirect  in  1  load PC from redirect_pc, flush
redirect_pc  in  ADDR_W  new PC

Behaviour:
- Reset: pc=RESET_PC, state=IDLE, instr=16'h0000, instr_pc=0, instr_valid=0, mem_rd=0, mem_addr=pc, latency counter=0.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE: if run=1 go to REQ, else stay.
- REQ (one cycle):
  - mem_rd=1, mem_addr=pc, load latency counter with MEM_LAT-1.
  - Go to WAIT if MEM_LAT>1; otherwise the next cycle is the capture cycle (WAIT with counter 0).
- WAIT: decrement counter each cycle. In the cycle with counter=0, capture: instr<=mem_rdata, instr_pc<=pc, pc<=pc+1 (modulo 2^ADDR_W, so 0xFFFF wraps to 0x0000 when ADDR_W=16), instr_valid<=1, go to HOLD.
- Fetch latency: run high in IDLE gives instr_valid 2+MEM_LAT cycles later (MEM_LAT=1: 3 cycles).
- HOLD: instr and instr_pc are stable while instr_valid=1. The transfer happens on a cycle with instr_valid&instr_ready.
  - Transfer with run=1: instr_valid<=0, go to REQ (no prefetch; one instruction outstanding at most).
  - Transfer with run=0: instr_valid<=0, go to IDLE.
- instr_ready is ignored when instr_valid=0.
- Redirect (any state) has highest priority: pc<=redirect_pc, instr_valid<=0, counter cleared, go to IDLE (then REQ if run=1).
  - Any read in flight is discarded; its mem_rdata is never captured.
  - Redirect concurrent with a transfer: the transfer is void, instruction dropped.
  - Redirect concurrent with reset: reset wins.
- run falling mid-fetch (REQ/WAIT): the fetch completes to HOLD; only new fetches are gated.
- Reset mid-fetch: all state returns to reset values next cycle; pending data ignored.
- mem_rd is never asserted in two consecutive cycles.
- instr_class is combinational from the instr register; the block performs no further decode.

Decomposition:
- Shared package cpu_pkg:
  - typedef instr_t (16-bit), typedef addr_t (ADDR_W-bit).
  - enum fetch_state_e {IDLE, REQ, WAIT, HOLD}.
  - Class constants CLS_INV=2'b00, CLS_FMT1=2'b01, CLS_ARITH=2'b10, CLS_FMT2=2'b11 (also used by the control FSM).
- Natural sub-module: pc_reg. Holds the PC with load (redirect), increment, and reset to RESET_PC, and outputs pc and pc+1. The FSM, latency counter and instruction register stay in fetch_unit.

Test Plan:
- Reset then run=1, MEM_LAT=1, memory[0]=16'h8053, instr_ready=1:
  - mem_rd at cycle 1 with addr 0.
  - instr_valid at cycle 3 with instr=16'h8053, instr_class=2'b10, instr_pc=0.
  - Next mem_rd with addr 1 in cycle 4.
- Backpressure, instr_ready=0 for 5 cycles in HOLD: instr/instr_pc stable, no mem_rd, pc=1. Assert ready: single transfer, then fetch of addr 1.
- Redirect in WAIT with MEM_LAT=3, redirect_pc=16'h0040:
  - In-flight word is not captured.
  - Next mem_addr=16'h0040; instr_pc=16'h0040 on the following valid.
- Redirect and transfer in the same cycle, redirect_pc=16'h0010: instruction dropped (no second transfer of it), next fetch from 16'h0010.
- Wrap: RESET_PC=16'hFFFF: first instr_pc=16'hFFFF, second fetch address 16'h0000.
- run deasserted in REQ: the fetch completes to HOLD. After accept the FSM sits in IDLE, mem_rd=0 for 10 cycles. Reasserting run resumes at pc. Reset asserted in WAIT: instr_valid=0 and pc=RESET_PC the next cycle.
